// File: rtl/lenet_ctrl_sequencer_if.sv
// Control bus between the layer sequencer and the datapath.
// The sequencer is master; the host and datapath side is slave.
interface lenet_ctrl_sequencer_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int N          = 5
);
  localparam int LW = (N * N > 1) ? $clog2(N * N) : 1;

  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic [2:0]            phase;
  logic                  ctrl_ram_en;
  logic                  ctrl_WorI;
  logic [2:0]            ctrl_mode;
  logic [1:0]            ctrl_mux_sel;
  logic                  ctrl_addr_ctrl_en;
  logic [ADDR_WIDTH-1:0] ctrl_read_addr;
  logic [LW-1:0]         ctrl_weight_location;

  modport master (
    input  start,
    input  abort,
    output busy,
    output done,
    output phase,
    output ctrl_ram_en,
    output ctrl_WorI,
    output ctrl_mode,
    output ctrl_mux_sel,
    output ctrl_addr_ctrl_en,
    output ctrl_read_addr,
    output ctrl_weight_location
  );

  modport slave (
    output start,
    output abort,
    input  busy,
    input  done,
    input  phase,
    input  ctrl_ram_en,
    input  ctrl_WorI,
    input  ctrl_mode,
    input  ctrl_mux_sel,
    input  ctrl_addr_ctrl_en,
    input  ctrl_read_addr,
    input  ctrl_weight_location
  );
endinterface

// File: rtl/lenet_ctrl_sequencer.sv
// Layer sequencer: weight preload, conv, pool and ReLU sweeps.
// Every output is a register updated by the single FSM block.
module lenet_ctrl_sequencer #(
  parameter int ADDR_WIDTH  = 11,
  parameter int N           = 5,
  parameter int WEIGHT_BASE = 1200,
  parameter int CONV_LEN    = 1200,
  parameter int POOL_LEN    = 1200,
  parameter int RELU_LEN    = 300,
  parameter int GAP         = 5
) (
  input  logic clk,
  input  logic rst,
  lenet_ctrl_sequencer_if.master bus
);

  localparam int LW = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int AW = ADDR_WIDTH;

  localparam logic [AW-1:0] A_ZERO = '0;
  localparam logic [AW-1:0] A_ONE  = AW'(1);
  localparam logic [AW-1:0] W_BASE = AW'(WEIGHT_BASE);
  localparam logic [AW-1:0] W_LAST = AW'(N * N - 1);
  localparam logic [AW-1:0] C_LAST = AW'(CONV_LEN - 1);
  localparam logic [AW-1:0] P_LAST = AW'(POOL_LEN - 1);
  localparam logic [AW-1:0] R_LAST = AW'(RELU_LEN - 1);
  localparam logic [GW-1:0] G_ONE  = GW'(1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);
  localparam logic [LW-1:0] L_ONE  = LW'(1);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_WLOAD = 3'd1;
  localparam logic [2:0] PH_WSET  = 3'd2;
  localparam logic [2:0] PH_CONV  = 3'd3;
  localparam logic [2:0] PH_GAP   = 3'd4;
  localparam logic [2:0] PH_POOL  = 3'd5;
  localparam logic [2:0] PH_RELU  = 3'd6;

  localparam logic [2:0] MODE_CONV = 3'b000;
  localparam logic [2:0] MODE_POOL = 3'b101;
  localparam logic [2:0] MODE_RELU = 3'b111;
  localparam logic [1:0] MUX_CONV  = 2'b00;
  localparam logic [1:0] MUX_POOL  = 2'b01;
  localparam logic [1:0] MUX_RELU  = 2'b10;

  // The two inter-sweep gaps share a phase code but
  // need distinct states so each knows its successor.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WSETTLE,
    S_CONV,
    S_GAP_C,
    S_POOL,
    S_GAP_P,
    S_RELU
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          busy_q;
  logic          done_q;
  logic [2:0]    phase_q;
  logic          ram_en_q;
  logic          wori_q;
  logic [2:0]    mode_q;
  logic [1:0]    mux_q;
  logic          ace_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] loc_q;

  // Sequencer FSM; outputs show the beat of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      phase_q  <= PH_IDLE;
      ram_en_q <= 1'b0;
      wori_q   <= 1'b0;
      mode_q   <= '0;
      mux_q    <= '0;
      ace_q    <= 1'b0;
      addr_q   <= '0;
      loc_q    <= '0;
    end else if (bus.abort) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      phase_q  <= PH_IDLE;
      ram_en_q <= 1'b0;
      wori_q   <= 1'b0;
      mode_q   <= '0;
      mux_q    <= '0;
      ace_q    <= 1'b0;
      addr_q   <= '0;
      loc_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state    <= S_WLOAD;
            busy_q   <= 1'b1;
            phase_q  <= PH_WLOAD;
            ram_en_q <= 1'b1;
            wori_q   <= 1'b1;
            addr_q   <= W_BASE;
            loc_q    <= '0;
            cnt      <= '0;
          end
        end
        S_WLOAD: begin
          if (cnt == W_LAST) begin
            state    <= S_WSETTLE;
            phase_q  <= PH_WSET;
            ram_en_q <= 1'b0;
            gcnt     <= '0;
          end else begin
            cnt    <= cnt + A_ONE;
            addr_q <= addr_q + A_ONE;
            loc_q  <= loc_q + L_ONE;
          end
        end
        S_WSETTLE: begin
          if (gcnt == G_LAST) begin
            state    <= S_CONV;
            phase_q  <= PH_CONV;
            wori_q   <= 1'b0;
            ram_en_q <= 1'b1;
            ace_q    <= 1'b1;
            mode_q   <= MODE_CONV;
            mux_q    <= MUX_CONV;
            addr_q   <= A_ZERO;
            loc_q    <= '0;
            cnt      <= '0;
          end else begin
            gcnt <= gcnt + G_ONE;
          end
        end
        S_CONV: begin
          if (cnt == C_LAST) begin
            state    <= S_GAP_C;
            phase_q  <= PH_GAP;
            ram_en_q <= 1'b0;
            ace_q    <= 1'b0;
            addr_q   <= A_ZERO;
            gcnt     <= '0;
          end else begin
            cnt    <= cnt + A_ONE;
            addr_q <= addr_q + A_ONE;
          end
        end
        S_GAP_C: begin
          if (gcnt == G_LAST) begin
            state    <= S_POOL;
            phase_q  <= PH_POOL;
            ram_en_q <= 1'b1;
            ace_q    <= 1'b1;
            mode_q   <= MODE_POOL;
            mux_q    <= MUX_POOL;
            addr_q   <= A_ZERO;
            cnt      <= '0;
          end else begin
            gcnt <= gcnt + G_ONE;
          end
        end
        S_POOL: begin
          if (cnt == P_LAST) begin
            state    <= S_GAP_P;
            phase_q  <= PH_GAP;
            ram_en_q <= 1'b0;
            ace_q    <= 1'b0;
            addr_q   <= A_ZERO;
            gcnt     <= '0;
          end else begin
            cnt    <= cnt + A_ONE;
            addr_q <= addr_q + A_ONE;
          end
        end
        S_GAP_P: begin
          if (gcnt == G_LAST) begin
            state    <= S_RELU;
            phase_q  <= PH_RELU;
            ram_en_q <= 1'b1;
            ace_q    <= 1'b0;
            mode_q   <= MODE_RELU;
            mux_q    <= MUX_RELU;
            addr_q   <= A_ZERO;
            cnt      <= '0;
          end else begin
            gcnt <= gcnt + G_ONE;
          end
        end
        S_RELU: begin
          if (cnt == R_LAST) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            phase_q  <= PH_IDLE;
            ram_en_q <= 1'b0;
            wori_q   <= 1'b0;
            mode_q   <= '0;
            mux_q    <= '0;
            ace_q    <= 1'b0;
            addr_q   <= A_ZERO;
            loc_q    <= '0;
            cnt      <= '0;
          end else begin
            cnt    <= cnt + A_ONE;
            addr_q <= addr_q + A_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.phase                = phase_q;
  assign bus.ctrl_ram_en          = ram_en_q;
  assign bus.ctrl_WorI            = wori_q;
  assign bus.ctrl_mode            = mode_q;
  assign bus.ctrl_mux_sel         = mux_q;
  assign bus.ctrl_addr_ctrl_en    = ace_q;
  assign bus.ctrl_read_addr       = addr_q;
  assign bus.ctrl_weight_location = loc_q;

endmodule

// File: tb/tb_lenet_ctrl_sequencer.sv
// Bench for lenet_ctrl_sequencer: expected beats are queued
// at each start; a negedge monitor pops them as outputs appear.
module tb_lenet_ctrl_sequencer;

  logic clk;
  logic rst;

  lenet_ctrl_sequencer_if #(.ADDR_WIDTH(11), .N(5)) bus ();

  lenet_ctrl_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0]  phase;
    logic        busy;
    logic        done;
    logic        ram_en;
    logic        wori;
    logic [2:0]  mode;
    logic [1:0]  mux;
    logic        ace;
    logic [10:0] addr;
    logic [4:0]  loc;
    logic        lchk;
  } vec_t;

  // Beat index boundaries of one default run, derived by hand:
  // 25 preload, 5 settle, 1200 conv, 5 gap, 1200 pool, 5 gap, 300 relu.
  localparam int J_SET  = 25;
  localparam int J_CONV = 30;
  localparam int J_GAPC = 1230;
  localparam int J_POOL = 1235;
  localparam int J_GAPP = 2435;
  localparam int J_RELU = 2440;
  localparam int J_DONE = 2740;

  vec_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   beat  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t exp_at(int j);
    vec_t v;
    v = '0;
    v.busy = 1'b1;
    if (j < J_SET) begin
      v.phase = 3'd1; v.ram_en = 1'b1; v.wori = 1'b1;
      v.addr = 11'(1200 + j); v.loc = 5'(j); v.lchk = 1'b1;
    end else if (j < J_CONV) begin
      v.phase = 3'd2; v.wori = 1'b1;
      v.addr = 11'd1224; v.loc = 5'd24; v.lchk = 1'b1;
    end else if (j < J_GAPC) begin
      v.phase = 3'd3; v.ram_en = 1'b1; v.ace = 1'b1;
      v.addr = 11'(j - J_CONV);
    end else if (j < J_POOL) begin
      v.phase = 3'd4;
    end else if (j < J_GAPP) begin
      v.phase = 3'd5; v.ram_en = 1'b1; v.ace = 1'b1;
      v.mode = 3'b101; v.mux = 2'b01;
      v.addr = 11'(j - J_POOL);
    end else if (j < J_RELU) begin
      v.phase = 3'd4; v.mode = 3'b101; v.mux = 2'b01;
    end else if (j < J_DONE) begin
      v.phase = 3'd6; v.ram_en = 1'b1;
      v.mode = 3'b111; v.mux = 2'b10;
      v.addr = 11'(j - J_RELU);
    end else begin
      v.busy = 1'b0; v.done = 1'b1; v.lchk = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {3'b0, bus.busy, bus.done, bus.phase,
            bus.ctrl_ram_en, bus.ctrl_WorI, bus.ctrl_mode,
            bus.ctrl_mux_sel, bus.ctrl_addr_ctrl_en,
            bus.ctrl_read_addr, bus.ctrl_weight_location};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  // Monitor: any cycle with busy or done must match the queue head.
  always @(negedge clk) begin
    if (bus.busy === 1'b1 || bus.done === 1'b1) begin
      vec_t a;
      vec_t e;
      a = {bus.phase, bus.busy, bus.done, bus.ctrl_ram_en,
           bus.ctrl_WorI, bus.ctrl_mode, bus.ctrl_mux_sel,
           bus.ctrl_addr_ctrl_en, bus.ctrl_read_addr,
           bus.ctrl_weight_location, 1'b0};
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output got %h exp none", a);
      end else begin
        e = q.pop_front();
        a.lchk = e.lchk;
        if (!e.lchk) begin
          a.loc = '0;
          e.loc = '0;
        end
        if (a !== e) begin
          n_err++;
          $display("FAIL beat%0d got %h (addr %0d) exp %h (addr %0d)",
                   beat, a, a.addr, e, e.addr);
        end
        beat++;
      end
    end
  end

  // Call at a negedge; returns at the negedge after the start edge.
  task automatic launch(int last);
    bus.start = 1'b1;
    for (int j = 0; j <= last; j++) q.push_back(exp_at(j));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout got no done exp done", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1 rst = 1'b1;
    #2 chk("reset_outputs", outs(), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", outs(), 32'h0);

    // Full run; extra start pulses inside CONV must be ignored.
    @(negedge clk);
    launch(J_DONE);
    repeat (79) @(posedge clk);
    repeat (4) begin
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
    end
    wait_done("run_a");

    // Start in the done cycle, then abort on POOL beat 600.
    launch(J_POOL + 600);
    repeat (J_POOL + 600) @(posedge clk);
    @(negedge clk) bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk("abort_outputs", outs(), 32'h0);
    chk("abort_queue", 32'(q.size()), 32'h0);

    // Replay after abort must begin again at the weight base.
    @(negedge clk);
    launch(J_DONE);
    wait_done("run_b");
    @(negedge clk);
    chk("run_b_queue", 32'(q.size()), 32'h0);

    // Abort and start together in IDLE: nothing starts.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_idle", outs(), 32'h0);
    repeat (10) @(negedge clk);
    chk("still_idle", outs(), 32'h0);

    // Asynchronous reset while CONV beat 100 is on the outputs.
    launch(J_CONV + 99);
    repeat (J_CONV + 100) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_reset", outs(), 32'h0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_after_mid_reset", outs(), 32'h0);
    chk("reset_queue", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
